popcount_scheduler: RTL
=======================

// Module: popcount_scheduler
// PURPOSE
//  Shares one iterative bit-reduction datapath between two requesters: the
//  branch-history logic (port 0) and the BTB-occupancy logic (port 1).
//  Each 32-bit word is reduced by pairwise field addition, one tree level per
//  clock, until one count of the set bits remains.
//  The block arbitrates round-robin, runs the levels and holds the count with
//  its requester ID until the consumer takes it.
// PARAMETERS
//  WIDTH   32  data word width; must be a power of two
//  LEVELS  5   reduction levels = log2(WIDTH); count width is LEVELS+1
// PORTS
//  clk        in   1          single clock; all state changes on rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  in_valid0  in   1          requester 0 presents a word
//  in_data0   in   WIDTH      requester 0 word
//  in_ready0  out  1          requester 0 word accepted this cycle
//  in_valid1  in   1          requester 1 presents a word
//  in_data1   in   WIDTH      requester 1 word
//  in_ready1  out  1          requester 1 word accepted this cycle
//  out_valid  out  1          count and ID are valid
//  out_count  out  LEVELS+1   number of set bits in the accepted word
//  out_id     out  1          requester that supplied the word
//  out_ready  in   1          consumer takes the result
//  busy       out  1          block is in the REDUCE or DONE state
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous) forces:
//   - state=IDLE; the vector, level counter, out_count and out_id go to 0.
//   - last_grant=1, so requester 0 wins the first contested arbitration.
//   - out_valid=0, busy=0, in_ready0/1=0 while reset is held.
//  The FSM has three states:
//   - IDLE: in_readyN = (state==IDLE) & grantN. in_readyN is combinational.
//     If only one in_validN is high, that requester is granted.
//     If both are high, the requester != last_grant is granted.
//     On an accept edge:
//       - vec <= the granted data; id <= the grant; last_grant <= the grant.
//       - lvl <= 0; the FSM goes to REDUCE.
//     If no in_valid is high, the FSM stays in IDLE and no register changes.
//   - REDUCE: each edge performs level lvl on vec.
//     - The field size is f=2^lvl. Each pair of adjacent f-bit fields is
//       summed into one 2f-bit field, zero-extended with no overflow loss.
//     - lvl increments. After the edge where lvl==LEVELS-1, the FSM goes to
//       DONE and out_count <= vec[LEVELS:0] as reduced.
//     - in_ready0/1 stay 0 throughout; input changes are ignored.
//   - DONE: out_valid=1. out_count and out_id stay stable until handshake.
//     - out_valid & out_ready at an edge moves the FSM to IDLE.
//     - A new word can be accepted on the next cycle at the earliest.
//     - While out_ready=0 the FSM holds DONE indefinitely.
//  Latency and throughput:
//   - If the word is accepted at edge T, out_valid is first high after edge
//     T+LEVELS (5 cycles for the default parameters).
//   - The best case is one result per LEVELS+2 cycles.
//  Output flags:
//   - busy = (state != IDLE).
//   - out_valid is 0 in IDLE and REDUCE.
//  Boundary conditions:
//   - An all-zero word gives count 0.
//   - An all-ones word gives count WIDTH (32 = 6'b100000); the result must not
//     wrap.
//   - When both requesters stay valid continuously, grants strictly alternate.
//   - If rst_n falls during REDUCE or DONE, the partial result is discarded and
//     no out_valid is produced for it.
//   - After reset releases, the FSM returns to IDLE with last_grant=1.
// TESTING
//  1 Only in_valid0 is high, with data 32'h0000_00FF. in_ready0 pulses for 1
//    cycle. 5 cycles later out_valid=1, out_count=8, out_id=0.
//  2 Only in_valid1 is high, with data 32'hFFFF_FFFF. The result is
//    out_count=32, out_id=1. Data 32'h0 gives out_count=0.
//  3 Both requesters are valid continuously and out_ready=1. Grant order
//    after reset is 0,1,0,1. Each count matches its own requester's data;
//    there is one result every 7 cycles.
//  4 Result in DONE with out_ready=0 for 10 cycles. out_valid, out_count and
//    out_id stay stable, and in_ready0/1 stay 0. The FSM returns to IDLE only
//    after out_ready=1.
//  5 Assert rst_n=0 mid-REDUCE, on the 3rd level. Outputs clear at once with
//    no clock needed. After release, a request from port 1 with both ports
//    valid grants port 0 first.
//  6 Run 1000 random words on both ports with random out_ready. Every count
//    equals the reference popcount of its word, and IDs match acceptance order.

Source files
------------

// File: rtl/popcount_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : popcount_scheduler
//  Purpose  : Two-requester round-robin front end for one shared iterative
//             population-count datapath. Each accepted word is reduced with
//             one pairwise-field-addition tree level per clock. The count is
//             then held, tagged with its requester ID, until the consumer
//             takes it.
//  Revision : 1.0 - initial release
// ============================================================================
module popcount_scheduler #(
    parameter int WIDTH  = 32,
    parameter int LEVELS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid0,
    input  logic [WIDTH-1:0]  in_data0,
    output logic              in_ready0,
    input  logic              in_valid1,
    input  logic [WIDTH-1:0]  in_data1,
    output logic              in_ready1,
    output logic              out_valid,
    output logic [LEVELS:0]   out_count,
    output logic              out_id,
    input  logic              out_ready,
    output logic              busy
);

    localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [WIDTH-1:0]        r_vec;
    logic [LVL_W-1:0]        r_lvl;
    logic [LEVELS:0]         r_count;
    logic                    r_id;
    logic                    r_last_grant;

    logic                    w_grant0;
    logic                    w_grant1;
    logic                    w_accept;
    logic                    w_last_lvl;
    logic [WIDTH-1:0]        w_reduced;
    logic [LEVELS-1:0][WIDTH-1:0] w_lvl_res;

    // Round-robin: a lone requester always wins; on contention the side that
    // did not win last time is chosen.
    assign w_grant0   = in_valid0 & (~in_valid1 | r_last_grant);
    assign w_grant1   = in_valid1 & (~in_valid0 | ~r_last_grant);
    assign w_accept   = (r_state == ST_IDLE) & (in_valid0 | in_valid1);
    assign w_last_lvl = (r_lvl == LVL_W'(LEVELS - 1));

    // Ready is gated by rst_n so nothing appears accepted while reset is held.
    assign in_ready0  = rst_n & (r_state == ST_IDLE) & w_grant0;
    assign in_ready1  = rst_n & (r_state == ST_IDLE) & w_grant1;

    assign out_valid  = (r_state == ST_DONE);
    assign busy       = (r_state != ST_IDLE);
    assign out_count  = r_count;
    assign out_id     = r_id;

    // Every tree level is built in parallel; level l adds adjacent 2^l-bit
    // fields into 2^(l+1)-bit fields. Field values never exceed the field
    // width, so the zero-extended sum cannot overflow.
    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        localparam int F = 1 << l;
        for (genvar j = 0; j < WIDTH / (2 * F); j++) begin : g_pair
            assign w_lvl_res[l][j*2*F +: 2*F] =
                {{F{1'b0}}, r_vec[j*2*F +: F]} + {{F{1'b0}}, r_vec[j*2*F+F +: F]};
        end
    end

    // Select the level that the current iteration performs.
    always_comb begin
        w_reduced = '0;
        for (int k = 0; k < LEVELS; k++) begin
            if (r_lvl == LVL_W'(k)) begin
                w_reduced = w_lvl_res[k];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept, iterate LEVELS times, then hold until taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)   w_state_nxt = ST_REDUCE;
            ST_REDUCE: if (w_last_lvl) w_state_nxt = ST_DONE;
            ST_DONE:   if (out_ready)  w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture the granted word, run one level per clock, latch count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec        <= '0;
            r_lvl        <= '0;
            r_count      <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_vec        <= w_grant1 ? in_data1 : in_data0;
                        r_id         <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_lvl        <= '0;
                    end
                end
                ST_REDUCE: begin
                    r_vec <= w_reduced;
                    r_lvl <= r_lvl + LVL_W'(1);
                    if (w_last_lvl) begin
                        r_count <= w_reduced[LEVELS:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
